id_fwd_stage: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register.
- Decodes the MIPS logic, shift and conditional-move subset.
- Reads the register file and resolves RAW hazards from NUM_FWD forwarding sources.
- Detects load-use hazards and raises a stall request.
- Registers decoded operands for EX, honouring downstream stall and flush.
- Keeps a saturating count of load-use stall cycles for performance monitoring.

---
 rtl/id_fwd_stage.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_id_fwd_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_fwd_stage
// Decode stage for the MIPS logic / shift / conditional-move subset, with
// register-file read control, multi-source RAW forwarding, load-use stall
// detection, an ID/EX pipeline register and a saturating stall counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_i, inst_i             PC and instruction word in ID
//   inst_valid_i             inst_i holds a real instruction
//   reg1/2_data_i            register-file read data
//   reg1/2_addr_o            register-file read addresses (rs / rt fields)
//   reg1/2_read_o            register-file read enables
//   fwd_wdata_i/wd_i/wreg_i  forwarding sources, slice k = source k,
//                            source 0 (EX) is youngest and wins
//   ex_is_load_i             source 0 is a load whose data is not ready
//   stall_i, flush_i         downstream hold / kill of the ID/EX register
//   stallreq_o               combinational load-use stall request
//   ex_*_o                   registered decode results for EX
//   stall_cnt_o              saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      inst_valid_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  output logic [4:0]                reg1_addr_o,
  output logic                      reg1_read_o,
  output logic [4:0]                reg2_addr_o,
  output logic                      reg2_read_o,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD*5-1:0]      fwd_wd_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic                      ex_is_load_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      stallreq_o,
  output logic [31:0]               ex_pc_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [4:0]                ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_valid_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [4:0]        wd;
    logic              wreg;
    logic              valid;
  } ex_t;

  // Instruction fields
  logic [5:0]  op_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;

  assign op_s    = inst_i[31:26];
  assign rs_s    = inst_i[25:21];
  assign rt_s    = inst_i[20:16];
  assign rd_s    = inst_i[15:11];
  assign shamt_s = inst_i[10:6];
  assign funct_s = inst_i[5:0];
  assign imm_s   = inst_i[15:0];

  // Decode outputs
  logic [7:0]        aluop_s;
  logic [2:0]        alusel_s;
  logic [4:0]        wd_s;
  logic              wreg_s;
  logic              valid_s;
  logic              rd1_s;
  logic              rd2_s;
  logic              is_movn_s;
  logic              is_movz_s;
  logic [DATA_W-1:0] imm1_s;
  logic [DATA_W-1:0] imm2_s;

  // Resolved operands and hazard terms
  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic              wreg_fin_s;
  logic              hit1_s;
  logic              hit2_s;
  logic              stallreq_s;

  ex_t               dec_s;
  ex_t               ex_d;
  ex_t               ex_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_q;

  // Instruction decode: op class, read enables, destination, immediates
  always_comb begin
    aluop_s   = 8'h00;
    alusel_s  = 3'b000;
    wd_s      = 5'd0;
    wreg_s    = 1'b0;
    valid_s   = 1'b0;
    rd1_s     = 1'b0;
    rd2_s     = 1'b0;
    is_movn_s = 1'b0;
    is_movz_s = 1'b0;
    imm1_s    = '0;
    imm2_s    = '0;
    if (inst_valid_i) begin
      case (op_s)
        6'h00: begin
          // An all-zero word is nop, not "sll $0,$0,0"
          if (inst_i != 32'h0000_0000) begin
            wd_s    = rd_s;
            wreg_s  = 1'b1;
            valid_s = 1'b1;
            case (funct_s)
              6'h24, 6'h25, 6'h26, 6'h27: begin
                aluop_s  = {2'b00, funct_s};
                alusel_s = 3'b001;
                rd1_s    = 1'b1;
                rd2_s    = 1'b1;
              end
              6'h00: begin
                aluop_s     = 8'h7C;
                alusel_s    = 3'b010;
                rd2_s       = 1'b1;
                imm1_s[4:0] = shamt_s;
              end
              6'h02, 6'h03: begin
                aluop_s     = {2'b00, funct_s};
                alusel_s    = 3'b010;
                rd2_s       = 1'b1;
                imm1_s[4:0] = shamt_s;
              end
              6'h04: begin
                aluop_s  = 8'h7C;
                alusel_s = 3'b010;
                rd1_s    = 1'b1;
                rd2_s    = 1'b1;
              end
              6'h06: begin
                aluop_s  = 8'h02;
                alusel_s = 3'b010;
                rd1_s    = 1'b1;
                rd2_s    = 1'b1;
              end
              6'h07: begin
                aluop_s  = 8'h03;
                alusel_s = 3'b010;
                rd1_s    = 1'b1;
                rd2_s    = 1'b1;
              end
              6'h0A: begin
                aluop_s   = 8'h0A;
                alusel_s  = 3'b011;
                rd1_s     = 1'b1;
                rd2_s     = 1'b1;
                is_movz_s = 1'b1;
              end
              6'h0B: begin
                aluop_s   = 8'h0B;
                alusel_s  = 3'b011;
                rd1_s     = 1'b1;
                rd2_s     = 1'b1;
                is_movn_s = 1'b1;
              end
              default: begin
                // sync and undefined functs decode as nop
                wd_s    = 5'd0;
                wreg_s  = 1'b0;
                valid_s = 1'b0;
              end
            endcase
          end else begin
            valid_s = 1'b0;
          end
        end
        6'h0C, 6'h0D, 6'h0E: begin
          // andi/ori/xori reuse the R-type aluops 0x24..0x26
          aluop_s      = {2'b00, 4'h2, op_s[1:0] - 2'b00 + 2'b00} + 8'h00;
          aluop_s      = 8'h24 + {6'b000000, op_s[1:0]};
          alusel_s     = 3'b001;
          rd1_s        = 1'b1;
          wd_s         = rt_s;
          wreg_s       = 1'b1;
          valid_s      = 1'b1;
          imm2_s[15:0] = imm_s;
        end
        6'h0F: begin
          aluop_s      = 8'h25;
          alusel_s     = 3'b001;
          wd_s         = rt_s;
          wreg_s       = 1'b1;
          valid_s      = 1'b1;
          imm2_s[31:0] = {imm_s, 16'h0000};
        end
        default: begin
          // pref and undefined opcodes decode as nop
          valid_s = 1'b0;
        end
      endcase
    end else begin
      valid_s = 1'b0;
    end
  end

  // Operand resolution: immediate, $0, youngest matching forward, regfile
  always_comb begin
    op1_s = imm1_s;
    op2_s = imm2_s;
    if (!rd1_s) begin
      op1_s = imm1_s;
    end else if (rs_s == 5'd0) begin
      op1_s = '0;
    end else begin
      op1_s = reg1_data_i;
      // Walk oldest to youngest so the lowest matching index wins
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        op1_s = (fwd_wreg_i[k] && (fwd_wd_i[k*5 +: 5] == rs_s)) ?
                fwd_wdata_i[k*DATA_W +: DATA_W] : op1_s;
      end
    end
    if (!rd2_s) begin
      op2_s = imm2_s;
    end else if (rt_s == 5'd0) begin
      op2_s = '0;
    end else begin
      op2_s = reg2_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        op2_s = (fwd_wreg_i[k] && (fwd_wd_i[k*5 +: 5] == rt_s)) ?
                fwd_wdata_i[k*DATA_W +: DATA_W] : op2_s;
      end
    end
  end

  // Conditional moves write only when the resolved rt satisfies the test
  always_comb begin
    if (is_movn_s) begin
      wreg_fin_s = (op2_s != '0);
    end else if (is_movz_s) begin
      wreg_fin_s = (op2_s == '0);
    end else begin
      wreg_fin_s = wreg_s;
    end
  end

  assign hit1_s = rd1_s && (rs_s != 5'd0) && (rs_s == fwd_wd_i[4:0]);
  assign hit2_s = rd2_s && (rt_s != 5'd0) && (rt_s == fwd_wd_i[4:0]);
  assign stallreq_s = !rst && inst_valid_i && ex_is_load_i && fwd_wreg_i[0] &&
                      (hit1_s || hit2_s);

  assign reg1_addr_o = rs_s;
  assign reg2_addr_o = rt_s;
  assign reg1_read_o = rd1_s && !rst;
  assign reg2_read_o = rd2_s && !rst;
  assign stallreq_o  = stallreq_s;

  assign dec_s = '{pc: pc_i, aluop: aluop_s, alusel: alusel_s, reg1: op1_s,
                   reg2: op2_s, wd: wd_s, wreg: wreg_fin_s, valid: valid_s};

  // ID/EX next state: flush beats downstream stall beats load-use bubble
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (stallreq_s) begin
      ex_d = '0;
    end else begin
      ex_d = dec_s;
    end
  end

  // Stall counter next state, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (stallreq_s && !flush_i && !stall_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ID/EX pipeline register and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_pc_o     = ex_q.pc;
  assign ex_aluop_o  = ex_q.aluop;
  assign ex_alusel_o = ex_q.alusel;
  assign ex_reg1_o   = ex_q.reg1;
  assign ex_reg2_o   = ex_q.reg2;
  assign ex_wd_o     = ex_q.wd;
  assign ex_wreg_o   = ex_q.wreg;
  assign ex_valid_o  = ex_q.valid;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        inst_valid_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        reg1_read_o, reg2_read_o;
  logic [63:0] fwd_wdata_i;
  logic [9:0]  fwd_wd_i;
  logic [1:0]  fwd_wreg_i;
  logic        ex_is_load_i, stall_i, flush_i, stallreq_o;
  logic [31:0] ex_pc_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o, ex_valid_o;
  logic [1:0]  stall_cnt_o;

  int passes = 0;
  int checks = 0;

  id_fwd_stage #(.DATA_W(32), .NUM_FWD(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
    .inst_valid_i(inst_valid_i), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .reg1_addr_o(reg1_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_addr_o(reg2_addr_o),
    .reg2_read_o(reg2_read_o), .fwd_wdata_i(fwd_wdata_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wreg_i(fwd_wreg_i),
    .ex_is_load_i(ex_is_load_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
    .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_valid_o(ex_valid_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_i = 32'h0; inst_i = 32'h0; inst_valid_i = 1'b0;
    reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    fwd_wdata_i = 64'h0; fwd_wd_i = 10'h0; fwd_wreg_i = 2'b00;
    ex_is_load_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    tick(); tick();
    chk("rst_valid", ex_valid_o, 1'b0);
    chk("rst_aluop", ex_aluop_o, 8'h00);
    chk("rst_cnt", stall_cnt_o, 2'd0);
    rst = 1'b0;

    // 1: ori $3,$1,0x00FF
    inst_i = 32'h3423_00FF; inst_valid_i = 1'b1; pc_i = 32'h100;
    reg1_data_i = 32'h1234_0000; reg2_data_i = 32'h55;
    #1;
    chk("ori_rd1", reg1_read_o, 1'b1);
    chk("ori_rd2", reg2_read_o, 1'b0);
    chk("ori_addr1", reg1_addr_o, 5'd1);
    chk("ori_stallreq", stallreq_o, 1'b0);
    tick();
    chk("ori_aluop", ex_aluop_o, 8'h25);
    chk("ori_alusel", ex_alusel_o, 3'b001);
    chk("ori_reg1", ex_reg1_o, 32'h1234_0000);
    chk("ori_reg2", ex_reg2_o, 32'h0000_00FF);
    chk("ori_wd", ex_wd_o, 5'd3);
    chk("ori_wreg", ex_wreg_o, 1'b1);
    chk("ori_valid", ex_valid_o, 1'b1);
    chk("ori_pc", ex_pc_o, 32'h100);

    // 2: or $4,$2,$2 forwarding priority
    inst_i = 32'h0042_2025; pc_i = 32'h104;
    reg1_data_i = 32'hDEAD; reg2_data_i = 32'hDEAD;
    fwd_wd_i = {5'd2, 5'd2}; fwd_wdata_i = {32'h5555, 32'hAAAA}; fwd_wreg_i = 2'b11;
    tick();
    chk("fwd0_reg1", ex_reg1_o, 32'hAAAA);
    chk("fwd0_reg2", ex_reg2_o, 32'hAAAA);
    chk("fwd0_wd", ex_wd_o, 5'd4);
    fwd_wreg_i = 2'b10;
    tick();
    chk("fwd1_reg1", ex_reg1_o, 32'h5555);
    chk("fwd1_reg2", ex_reg2_o, 32'h5555);
    inst_i = 32'h0000_2025; fwd_wd_i = 10'h0; fwd_wreg_i = 2'b11;
    tick();
    chk("zero_reg1", ex_reg1_o, 32'h0);
    chk("zero_reg2", ex_reg2_o, 32'h0);
    chk("zero_valid", ex_valid_o, 1'b1);

    // 3: load-use on and $6,$5,$7
    inst_i = 32'h00A7_3024; pc_i = 32'h108; ex_is_load_i = 1'b1;
    fwd_wd_i = {5'd0, 5'd5}; fwd_wreg_i = 2'b01; fwd_wdata_i = {32'h0, 32'h0F0F};
    reg1_data_i = 32'h1111; reg2_data_i = 32'h3333;
    #1;
    chk("lu_stallreq", stallreq_o, 1'b1);
    tick();
    chk("lu_bubble_valid", ex_valid_o, 1'b0);
    chk("lu_bubble_wreg", ex_wreg_o, 1'b0);
    chk("lu_bubble_pc", ex_pc_o, 32'h0);
    chk("lu_cnt", stall_cnt_o, 2'd1);
    ex_is_load_i = 1'b0;
    #1;
    chk("lu_release", stallreq_o, 1'b0);
    tick();
    chk("lu_reg1", ex_reg1_o, 32'h0F0F);
    chk("lu_reg2", ex_reg2_o, 32'h3333);
    chk("lu_valid", ex_valid_o, 1'b1);
    chk("lu_aluop", ex_aluop_o, 8'h24);
    chk("lu_wd", ex_wd_o, 5'd6);
    chk("lu_cnt_hold", stall_cnt_o, 2'd1);

    // 4: downstream stall holds, and load-use under stall is not counted
    stall_i = 1'b1; ex_is_load_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_reg1", ex_reg1_o, 32'h0F0F);
      chk("stall_valid", ex_valid_o, 1'b1);
      chk("stall_pc", ex_pc_o, 32'h108);
      chk("stall_cnt", stall_cnt_o, 2'd1);
    end
    flush_i = 1'b1;
    tick();
    chk("flush_valid", ex_valid_o, 1'b0);
    chk("flush_reg1", ex_reg1_o, 32'h0);
    chk("flush_cnt", stall_cnt_o, 2'd1);
    flush_i = 1'b0; stall_i = 1'b0; ex_is_load_i = 1'b0; fwd_wreg_i = 2'b00;
    inst_i = 32'h3423_00FF; pc_i = 32'h10C; reg1_data_i = 32'h1234_0000;
    tick();
    chk("reload_valid", ex_valid_o, 1'b1);
    rst = 1'b1; flush_i = 1'b1;
    inst_i = 32'h00A7_3024; ex_is_load_i = 1'b1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd5};
    #1;
    chk("rst_stallreq", stallreq_o, 1'b0);
    chk("rst_rd1", reg1_read_o, 1'b0);
    chk("rst_rd2", reg2_read_o, 1'b0);
    tick();
    chk("rstf_valid", ex_valid_o, 1'b0);
    chk("rstf_reg1", ex_reg1_o, 32'h0);
    chk("rstf_pc", ex_pc_o, 32'h0);
    chk("rstf_cnt", stall_cnt_o, 2'd0);
    rst = 1'b0; flush_i = 1'b0; ex_is_load_i = 1'b0;

    // 5: movz/movn with rt forwarded
    inst_i = 32'h012A_400A; pc_i = 32'h110;
    fwd_wd_i = {5'd0, 5'd10}; fwd_wdata_i = 64'h0; fwd_wreg_i = 2'b01;
    reg1_data_i = 32'h99; reg2_data_i = 32'h77;
    tick();
    chk("movz0_wreg", ex_wreg_o, 1'b1);
    chk("movz0_aluop", ex_aluop_o, 8'h0A);
    chk("movz0_alusel", ex_alusel_o, 3'b011);
    chk("movz0_reg1", ex_reg1_o, 32'h99);
    chk("movz0_reg2", ex_reg2_o, 32'h0);
    inst_i = 32'h012A_400B;
    tick();
    chk("movn0_wreg", ex_wreg_o, 1'b0);
    chk("movn0_valid", ex_valid_o, 1'b1);
    chk("movn0_aluop", ex_aluop_o, 8'h0B);
    fwd_wdata_i = {32'h0, 32'h1};
    tick();
    chk("movn1_wreg", ex_wreg_o, 1'b1);
    inst_i = 32'h012A_400A;
    tick();
    chk("movz1_wreg", ex_wreg_o, 1'b0);

    // 6: counter saturation, then sll
    inst_i = 32'h00A7_3024; ex_is_load_i = 1'b1;
    fwd_wd_i = {5'd0, 5'd5}; fwd_wreg_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_cnt", stall_cnt_o, (i < 3) ? 2'(i + 1) : 2'd3);
      chk("sat_valid", ex_valid_o, 1'b0);
    end
    inst_i = 32'h0003_1100; ex_is_load_i = 1'b0; fwd_wreg_i = 2'b00;
    reg2_data_i = 32'h80;
    #1;
    chk("sll_rd1", reg1_read_o, 1'b0);
    chk("sll_rd2", reg2_read_o, 1'b1);
    chk("sll_stallreq", stallreq_o, 1'b0);
    tick();
    chk("sll_reg1", ex_reg1_o, 32'h4);
    chk("sll_reg2", ex_reg2_o, 32'h80);
    chk("sll_aluop", ex_aluop_o, 8'h7C);
    chk("sll_alusel", ex_alusel_o, 3'b010);
    chk("sll_wd", ex_wd_o, 5'd2);
    chk("sll_cnt", stall_cnt_o, 2'd3);

    // 7: lui, invalid slot, nop
    inst_i = 32'h3C07_ABCD;
    tick();
    chk("lui_reg1", ex_reg1_o, 32'h0);
    chk("lui_reg2", ex_reg2_o, 32'hABCD_0000);
    chk("lui_wd", ex_wd_o, 5'd7);
    chk("lui_aluop", ex_aluop_o, 8'h25);
    inst_i = 32'h3423_00FF; inst_valid_i = 1'b0;
    tick();
    chk("inv_valid", ex_valid_o, 1'b0);
    chk("inv_aluop", ex_aluop_o, 8'h00);
    inst_i = 32'h0000_0000; inst_valid_i = 1'b1;
    tick();
    chk("nop_valid", ex_valid_o, 1'b0);
    chk("nop_wreg", ex_wreg_o, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
